clefia_gfn_dec_seq: RTL and testbench

// - Decryption-direction data sequencer for CLEFIA: runs whitening + GFN^-1_{4,r} on one 128-bit

---
 rtl/clefia_pkg.sv | 42 ++++
 rtl/clefia_gfn_dec_seq.sv | 160 ++++++++++++++++
 tb/tb_clefia_gfn_dec_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/clefia_pkg.sv
// Shared definitions for the CLEFIA decryption-direction data sequencer.
//   - sequencer state encoding
//   - legal round counts for 128/192/256-bit keys
//   - word width and word-index constants for {W0,W1,W2,W3} 128-bit blocks,
//     where W0 occupies bits [127:96]
package clefia_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 4 * WORD_W;

  localparam logic [4:0] NR_128 = 5'd18;
  localparam logic [4:0] NR_192 = 5'd22;
  localparam logic [4:0] NR_256 = 5'd26;

  // Word positions inside a block: index 0 is the most significant word.
  localparam logic [1:0] W0 = 2'd0;
  localparam logic [1:0] W1 = 2'd1;
  localparam logic [1:0] W2 = 2'd2;
  localparam logic [1:0] W3 = 2'd3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RF0  = 2'd1,
    ST_RF1  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Extract word idx (0 = MSW) from a 128-bit block.
  function automatic word_t blk_word(input logic [BLK_W-1:0] b, input logic [1:0] idx);
    word_t w;
    case (idx)
      W0:      w = b[127:96];
      W1:      w = b[95:64];
      W2:      w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/clefia_gfn_dec_seq.sv
// CLEFIA decryption-direction data sequencer.
// Applies output whitening removal, then GFN^-1_{4,r} one F-function per cycle
// (RF0 evaluates F0 on T0 into T1, RF1 evaluates F1 on T2 into T3), then the
// final whitening. The F0/F1 unit and round-key storage live in the parent;
// this block only presents f_sel/f_x/f_rk_idx and consumes f_res in the same cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   nr                round count 18/22/26 (others fall back to NR_DEF), sampled on accept
//   in_valid/in_ready ciphertext handshake; in_ready=1 only in IDLE
//   ct                ciphertext {C0,C1,C2,C3}
//   wk                whitening keys {WK0,WK1,WK2,WK3}, held stable while busy
//   f_sel             0 = F0, 1 = F1
//   f_x               F-function data input
//   f_rk_idx          round-key index for the F unit
//   f_res             F(RK[f_rk_idx], f_x), combinational
//   out_valid/out_ready plaintext handshake
//   pt                plaintext {P0,P1,P2,P3}
//   busy              high while a block is in flight or waiting at the output
module clefia_gfn_dec_seq
  import clefia_pkg::*;
#(
  parameter int unsigned NR_DEF = 18,
  parameter int unsigned RKW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       nr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ct,
  input  logic [BLK_W-1:0] wk,
  output logic             f_sel,
  output logic [WORD_W-1:0] f_x,
  output logic [RKW-1:0]   f_rk_idx,
  input  logic [WORD_W-1:0] f_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] pt,
  output logic             busy
);

  // Unsupported round counts decode as the default key size.
  function automatic logic [4:0] nr_legal(input logic [4:0] n);
    logic [4:0] r;
    case (n)
      NR_128, NR_192, NR_256: r = n;
      default:                r = 5'(NR_DEF);
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       rnd_q, rnd_d;
  word_t            t0_q, t0_d;
  word_t            t1_q, t1_d;
  word_t            t2_q, t2_d;
  word_t            t3_q, t3_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic             out_valid_q, out_valid_d;
  word_t            t3n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t3_q        <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      t3_q        <= t3_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    t3_d        = t3_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    t3n         = '0;
    in_ready    = 1'b0;
    f_sel       = 1'b0;
    f_x         = '0;
    f_rk_idx    = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Undo the encryption-side output whitening on words 1 and 3.
          t0_d    = blk_word(ct, W0);
          t1_d    = blk_word(ct, W1) ^ blk_word(wk, W2);
          t2_d    = blk_word(ct, W2);
          t3_d    = blk_word(ct, W3) ^ blk_word(wk, W3);
          rnd_d   = nr_legal(nr) - 5'd1;
          state_d = ST_RF0;
        end
      end

      ST_RF0: begin
        f_sel    = 1'b0;
        f_x      = t0_q;
        f_rk_idx = RKW'({rnd_q, 1'b0});
        t1_d     = t1_q ^ f_res;
        state_d  = ST_RF1;
      end

      ST_RF1: begin
        f_sel    = 1'b1;
        f_x      = t2_q;
        f_rk_idx = RKW'({rnd_q, 1'b1});
        t3n      = t3_q ^ f_res;
        if (rnd_q != 5'd0) begin
          // Inverse of the encryption word rotation: words shift right by one.
          t0_d    = t3n;
          t1_d    = t0_q;
          t2_d    = t1_q;
          t3_d    = t2_q;
          rnd_d   = rnd_q - 5'd1;
          state_d = ST_RF0;
        end else begin
          // Last round is unrotated; remove the input whitening on the way out.
          pt_d        = {t0_q, t1_q ^ blk_word(wk, W0), t2_q, t3n ^ blk_word(wk, W1)};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign pt        = pt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clefia_gfn_dec_seq.sv
module tb_clefia_gfn_dec_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   nr;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] wk;
  logic         f_sel;
  logic [31:0]  f_x;
  logic [5:0]   f_rk_idx;
  logic [31:0]  f_res;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] rk [64];

  clefia_gfn_dec_seq #(.NR_DEF(18), .RKW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .nr        (nr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .wk        (wk),
    .f_sel     (f_sel),
    .f_x       (f_x),
    .f_rk_idx  (f_rk_idx),
    .f_res     (f_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in keyed nonlinear F0/F1 pair; the sequencer is agnostic to F's contents.
  function automatic logic [31:0] fmodel(input logic sel, input logic [31:0] x, input logic [31:0] k);
    logic [31:0] v;
    v = x ^ k;
    v = v * 32'h9E37_79B1;
    v = v ^ (v >> 15);
    if (sel) v = {v[7:0], v[31:8]} ^ 32'h5A5A_C3C3;
    else     v = v ^ (v << 7);
    return v;
  endfunction

  always_comb f_res = fmodel(f_sel, f_x, rk[f_rk_idx]);

  // Forward CLEFIA GFN_{4,r} encryption with whitening; decryption must invert it.
  function automatic logic [127:0] enc_blk(input logic [127:0] p, input logic [127:0] w, input int r);
    logic [31:0] t [4];
    logic [31:0] tmp;
    t[0] = p[127:96];
    t[1] = p[95:64] ^ w[127:96];
    t[2] = p[63:32];
    t[3] = p[31:0]  ^ w[95:64];
    for (int i = 0; i < r; i++) begin
      t[1] = t[1] ^ fmodel(1'b0, t[0], rk[2*i]);
      t[3] = t[3] ^ fmodel(1'b1, t[2], rk[2*i+1]);
      if (i < r - 1) begin
        tmp  = t[0];
        t[0] = t[1];
        t[1] = t[2];
        t[2] = t[3];
        t[3] = tmp;
      end
    end
    return {t[0], t[1] ^ w[63:32], t[2], t[3] ^ w[31:0]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block from accept to handshake, tracing the F-unit interface on the way.
  task automatic run_block(input logic [127:0] p, input logic [4:0] nr_in, input int r, input bit stall);
    logic [127:0] hold;
    int cyc;
    ct       = enc_blk(p, wk, r);
    nr       = nr_in;
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    ct = rnd128();
    nr = 5'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      chk("f_sel", 128'(f_sel), 128'(cyc % 2));
      chk("f_rk_idx", 128'(f_rk_idx), 128'(2 * (r - 1 - cyc / 2) + cyc % 2));
      chk("busy_rounds", 128'({busy, in_ready}), 128'(2'b10));
      if (cyc % 4 == 1) in_valid = 1'b1;
      else              in_valid = 1'b0;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(cyc), 128'(2 * r));
    chk("pt", pt, p);
    chk("done_f_if", 128'({f_sel, f_x, f_rk_idx}), 128'(0));
    chk("done_ready_busy", 128'({in_ready, busy}), 128'(2'b01));
    if (stall) begin
      hold = pt;
      for (int i = 0; i < 10; i++) begin
        in_valid = (i % 2 == 0);
        ct = rnd128();
        tick();
        chk("stall_pt", pt, hold);
        chk("stall_valid_ready", 128'({out_valid, in_ready}), 128'(2'b10));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff", 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  logic [127:0] pq [$];
  logic [127:0] pv [4];
  int nacc, nout, cyc, last_acc;
  bit acc_now, hs_now;

  initial begin
    for (int i = 0; i < 64; i++) rk[i] = $urandom;
    wk        = rnd128();
    rst       = 1'b1;
    nr        = 5'd18;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct        = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outputs", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("rst_pt", pt, 128'(0));
    chk("rst_f_if", 128'({f_sel, f_x, f_rk_idx}), 128'(0));

    run_block(rnd128(), 5'd18, 18, 1'b0);
    run_block(rnd128(), 5'd18, 18, 1'b1);
    run_block(rnd128(), 5'd22, 22, 1'b0);
    run_block(rnd128(), 5'd22, 22, 1'b0);
    run_block(rnd128(), 5'd26, 26, 1'b0);
    run_block(rnd128(), 5'd26, 26, 1'b1);
    run_block(rnd128(), 5'd7,  18, 1'b0);
    run_block(rnd128(), 5'd0,  18, 1'b0);

    // Abort a block part way through with reset.
    ct = enc_blk(rnd128(), wk, 18);
    nr = 5'd18;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("abort_pt", pt, 128'(0));
    run_block(rnd128(), 5'd18, 18, 1'b0);

    // Continuous streaming with both handshakes held high.
    for (int i = 0; i < 4; i++) pv[i] = rnd128();
    nr = 5'd18;
    ct = enc_blk(pv[0], wk, 18);
    in_valid = 1'b1;
    out_ready = 1'b1;
    nacc = 0;
    nout = 0;
    cyc = 0;
    last_acc = 0;
    while (nout < 4 && cyc < 400) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      if (hs_now) begin
        if (pq.size() > 0) chk("b2b_pt", pt, pq.pop_front());
        else               chk("b2b_spurious_out", 128'(1), 128'(0));
        nout++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (nacc > 0) chk("b2b_period", 128'(cyc - last_acc), 128'(38));
        last_acc = cyc;
        pq.push_back(pv[nacc]);
        nacc++;
        if (nacc < 4) ct = enc_blk(pv[nacc], wk, 18);
        else          in_valid = 1'b0;
      end
    end
    chk("b2b_count", 128'(nout), 128'(4));
    out_ready = 1'b0;
    tick();
    chk("b2b_idle", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
